// File: rtl/bp_update_sched_pkg.sv
// Shared constants, state encoding and counter helper for the branch-predictor update scheduler.
package bp_update_sched_pkg;

    localparam int DBITS_DEF     = 32;
    localparam int PHT_IDX_W     = 8;
    localparam int BTB_IDX_W     = 4;
    localparam int QDEPTH_DEF    = 4;
    localparam int BTB_ENTRY_W   = 59;
    localparam int BTB_VALID_BIT = 58;
    localparam int UPD_REC_W     = DBITS_DEF * 2 + 1 + PHT_IDX_W;

    localparam logic [1:0] SAT_MAX = 2'd3;
    localparam logic [1:0] SAT_MIN = 2'd0;

    typedef enum logic [2:0] {
        INIT_PHT,
        INIT_BTB,
        IDLE,
        READ,
        WRITE
    } upd_state_e;

    // 2-bit saturating step toward the resolved direction; never wraps.
    function automatic logic [1:0] sat_update(input logic [1:0] cur, input logic taken);
        if (taken) begin
            return (cur == SAT_MAX) ? SAT_MAX : cur + 2'd1;
        end
        return (cur == SAT_MIN) ? SAT_MIN : cur - 2'd1;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small power-of-two FIFO holding resolved-branch update records; async active-low reset.
module bp_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 73
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/bp_update_sched.sv
// Clears PHT/BTB after reset, then serialises queued AGEX branch updates onto the table write ports.
// Define BP_UPD_PIPELINE_EN for overlapped READ/WRITE (1 update/cycle) with counter forwarding.
module bp_update_sched
    import bp_update_sched_pkg::*;
#(
    parameter int DBITS        = DBITS_DEF,
    parameter int PHT_IDX_BITS = PHT_IDX_W,
    parameter int BTB_IDX_BITS = BTB_IDX_W,
    parameter int QDEPTH       = QDEPTH_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              upd_valid,
    output logic                              upd_ready,
    input  logic [DBITS-1:0]                  upd_pc,
    input  logic [DBITS-1:0]                  upd_target,
    input  logic                              upd_taken,
    input  logic [PHT_IDX_BITS-1:0]           upd_pht_idx,
    output logic                              pht_rd_en,
    output logic [PHT_IDX_BITS-1:0]           pht_rd_idx,
    input  logic [1:0]                        pht_rd_data,
    output logic                              pht_wr_en,
    output logic [PHT_IDX_BITS-1:0]           pht_wr_idx,
    output logic [1:0]                        pht_wr_data,
    output logic                              btb_wr_en,
    output logic [BTB_IDX_BITS-1:0]           btb_wr_idx,
    output logic [2*DBITS-BTB_IDX_BITS-2:0]   btb_wr_data,
    output logic [7:0]                        bhr,
    output logic                              init_busy
);
    localparam int REC_W = 2 * DBITS + 1 + PHT_IDX_BITS;
    localparam int CNT_W = $clog2(QDEPTH) + 1;

    upd_state_e              state_q, state_d;
    logic [PHT_IDX_BITS-1:0] cnt_q, cnt_d;
    logic [7:0]              bhr_q, bhr_d;

    logic                    push, pop, fifo_full, fifo_empty;
    logic [REC_W-1:0]        push_rec, head_rec, cur_rec;
    logic [CNT_W-1:0]        fifo_count;
    logic [DBITS-1:0]        cur_pc, cur_target;
    logic                    cur_taken;
    logic [PHT_IDX_BITS-1:0] cur_idx, head_idx;
    logic [1:0]              old_ctr, new_ctr;

    assign init_busy = (state_q == INIT_PHT) || (state_q == INIT_BTB);
    assign upd_ready = !init_busy && !fifo_full;
    assign push      = upd_valid && upd_ready;
    assign push_rec  = {upd_pc, upd_target, upd_taken, upd_pht_idx};
    assign head_idx  = head_rec[PHT_IDX_BITS-1:0];
    assign {cur_pc, cur_target, cur_taken, cur_idx} = cur_rec;
    assign new_ctr   = sat_update(old_ctr, cur_taken);
    assign bhr       = bhr_q;

    bp_upd_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (push),
        .push_data_i (push_rec),
        .pop_i       (pop),
        .head_o      (head_rec),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

`ifdef BP_UPD_PIPELINE_EN
    // The record is popped when its read issues, so WRITE works from a stage copy
    // while the next head's read overlaps it.
    logic [REC_W-1:0] stg_q, stg_d;
    logic             fwd_hit_q, fwd_hit_d;
    logic [1:0]       fwd_val_q, fwd_val_d;

    assign cur_rec = stg_q;
    assign old_ctr = fwd_hit_q ? fwd_val_q : pht_rd_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg_q     <= '0;
            fwd_hit_q <= 1'b0;
            fwd_val_q <= 2'd0;
        end else begin
            stg_q     <= stg_d;
            fwd_hit_q <= fwd_hit_d;
            fwd_val_q <= fwd_val_d;
        end
    end
`else
    assign cur_rec = head_rec;
    assign old_ctr = pht_rd_data;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= INIT_PHT;
            cnt_q   <= '0;
            bhr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bhr_q   <= bhr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bhr_d       = bhr_q;
        pop         = 1'b0;
        pht_rd_en   = 1'b0;
        pht_rd_idx  = '0;
        pht_wr_en   = 1'b0;
        pht_wr_idx  = '0;
        pht_wr_data = '0;
        btb_wr_en   = 1'b0;
        btb_wr_idx  = '0;
        btb_wr_data = '0;
`ifdef BP_UPD_PIPELINE_EN
        stg_d       = stg_q;
        fwd_hit_d   = 1'b0;
        fwd_val_d   = fwd_val_q;
`endif
        // Table strobes stay off while reset is held so the sweep starts cleanly on release.
        if (reset) begin
            unique case (state_q)
                INIT_PHT: begin
                    pht_wr_en  = 1'b1;
                    pht_wr_idx = cnt_q;
                    if (cnt_q == '1) begin
                        cnt_d   = '0;
                        state_d = INIT_BTB;
                    end else begin
                        cnt_d = cnt_q + PHT_IDX_BITS'(1);
                    end
                end
                INIT_BTB: begin
                    btb_wr_en  = 1'b1;
                    btb_wr_idx = cnt_q[BTB_IDX_BITS-1:0];
                    if (cnt_q[BTB_IDX_BITS-1:0] == '1) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + PHT_IDX_BITS'(1);
                    end
                end
                IDLE: begin
                    if (!fifo_empty) begin
                        state_d = READ;
                    end
                end
                READ: begin
                    pht_rd_en  = 1'b1;
                    pht_rd_idx = head_idx;
                    state_d    = WRITE;
`ifdef BP_UPD_PIPELINE_EN
                    pop        = 1'b1;
                    stg_d      = head_rec;
`endif
                end
                WRITE: begin
                    pht_wr_en   = 1'b1;
                    pht_wr_idx  = cur_idx;
                    pht_wr_data = new_ctr;
                    btb_wr_en   = 1'b1;
                    btb_wr_idx  = cur_pc[BTB_IDX_BITS+1:2];
                    btb_wr_data = {1'b1, cur_pc[DBITS-1:BTB_IDX_BITS+2], cur_target};
                    bhr_d       = {bhr_q[6:0], cur_taken};
`ifdef BP_UPD_PIPELINE_EN
                    if (!fifo_empty) begin
                        pht_rd_en  = 1'b1;
                        pht_rd_idx = head_idx;
                        pop        = 1'b1;
                        stg_d      = head_rec;
                        fwd_hit_d  = (head_idx == cur_idx);
                        fwd_val_d  = new_ctr;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    pop     = 1'b1;
                    state_d = (fifo_count > CNT_W'(1)) ? READ : IDLE;
`endif
                end
                default: state_d = INIT_PHT;
            endcase
        end
    end

endmodule
